// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds the controller state encodings, the default index width and a
// small helper that classifies a core write as a whole aligned word.
package dcache_pkg;

    localparam int INDEX_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MISS = 2'b01,
        ST_FILL = 2'b11
    } state_t;

    // Only an aligned, all-lanes write can refresh a line in place; any
    // narrower write to a cached line has to drop that line instead.
    function automatic logic is_full_word(input logic [3:0] strb,
                                          input logic [1:0] offset);
        return (strb == 4'hF) && (offset == 2'b00);
    endfunction

endpackage

// File: rtl/dcache_dm_wt_if.sv
// Memory-side bus between the data cache and the AXI translate stage.
// master: the cache (issues read/write requests, consumes read responses).
// slave : the translate stage.
//   MEM_RSELECT/MEM_RDEN/MEM_RIADDR        read request
//   MEM_RVALID/MEM_RDATA/MEM_ROADDR        read response
//   MEM_WSELECT/MEM_WREN/MEM_WSTRB/
//   MEM_WADDR/MEM_WDATA                    write request
//   MEM_LOADING                            translate stage busy
interface dcache_dm_wt_if;

    logic        MEM_RSELECT;
    logic        MEM_RDEN;
    logic [31:0] MEM_RIADDR;
    logic        MEM_RVALID;
    logic [31:0] MEM_RDATA;
    logic [31:0] MEM_ROADDR;
    logic        MEM_WSELECT;
    logic        MEM_WREN;
    logic [3:0]  MEM_WSTRB;
    logic [31:0] MEM_WADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_LOADING;

    modport master (
        output MEM_RSELECT, MEM_RDEN, MEM_RIADDR,
        input  MEM_RVALID, MEM_RDATA, MEM_ROADDR,
        output MEM_WSELECT, MEM_WREN, MEM_WSTRB, MEM_WADDR, MEM_WDATA,
        input  MEM_LOADING
    );

    modport slave (
        input  MEM_RSELECT, MEM_RDEN, MEM_RIADDR,
        output MEM_RVALID, MEM_RDATA, MEM_ROADDR,
        input  MEM_WSELECT, MEM_WREN, MEM_WSTRB, MEM_WADDR, MEM_WDATA,
        output MEM_LOADING
    );

endinterface

// File: rtl/dcache_dm_array.sv
// Tag + data storage for the direct-mapped cache, one word per line.
// Ports:
//   CLK, RST                 clock; RST clears every valid bit (sync)
//   rd_idx -> rd_valid/rd_tag/rd_data      combinational lookup port
//   probe_idx -> probe_valid/probe_tag     combinational tag probe used to
//                                          classify core writes as hit/miss
//   we, wr_idx, wr_tag, wr_data            line write (also sets valid)
//   inv, inv_idx                           line invalidate
// Tag and data contents are not reset; only the valid vector is.
module dcache_dm_array #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic [INDEX_W-1:0] probe_idx,
    output logic               probe_valid,
    output logic [TAG_W-1:0]   probe_tag,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data,
    input  logic               inv,
    input  logic [INDEX_W-1:0] inv_idx
);

    localparam int LINES = 1 << INDEX_W;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [LINES-1:0] valid;

    assign rd_valid    = valid[rd_idx];
    assign rd_tag      = tag_mem[rd_idx];
    assign rd_data     = data_mem[rd_idx];
    assign probe_valid = valid[probe_idx];
    assign probe_tag   = tag_mem[probe_idx];

    always_ff @(posedge CLK) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    // Invalidate is evaluated after the write so it wins on a shared index.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= '0;
        end else begin
            if (we) begin
                valid[wr_idx] <= 1'b1;
            end
            if (inv) begin
                valid[inv_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines. Read hits answer one cycle later; misses fetch the word from the
// translate stage and then replay the held request as a hit.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   STALL                          holds the read response registers
//   LOADING                        core must hold its request while high
//   RDEN/RADDR                     core read request
//   RVALID/RDATA/ROADDR            registered read response
//   WREN/WSTRB/WADDR/WDATA         core write request
//   mem                            memory-side bus (dcache_dm_wt_if.master)
module dcache_dm_wt
    import dcache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           STALL,
    output logic           LOADING,
    input  logic           RDEN,
    input  logic [31:0]    RADDR,
    output logic           RVALID,
    output logic [31:0]    RDATA,
    output logic [31:0]    ROADDR,
    input  logic           WREN,
    input  logic [3:0]     WSTRB,
    input  logic [31:0]    WADDR,
    input  logic [31:0]    WDATA,
    dcache_dm_wt_if.master mem
);

    localparam int TAG_W = 30 - INDEX_W;

    state_t state, state_nxt;

    logic [INDEX_W-1:0] r_idx, w_idx;
    logic [TAG_W-1:0]   r_tag, w_tag;
    logic               rd_valid, probe_valid;
    logic [TAG_W-1:0]   rd_tag, probe_tag;
    logic [31:0]        rd_data;
    logic               hit, w_hit, w_acc, w_full;
    logic               fill_evt, do_fill, w_upd, w_inv, new_resp;
    logic               arr_we;
    logic [INDEX_W-1:0] arr_idx;
    logic [TAG_W-1:0]   arr_tag;
    logic [31:0]        arr_data;
    logic               rd_req;
    logic               unused_roaddr;

    assign r_idx = RADDR[INDEX_W+1:2];
    assign r_tag = RADDR[31:INDEX_W+2];
    assign w_idx = WADDR[INDEX_W+1:2];
    assign w_tag = WADDR[31:INDEX_W+2];

    dcache_dm_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .CLK         (CLK),
        .RST         (RST),
        .rd_idx      (r_idx),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .probe_idx   (w_idx),
        .probe_valid (probe_valid),
        .probe_tag   (probe_tag),
        .we          (arr_we),
        .wr_idx      (arr_idx),
        .wr_tag      (arr_tag),
        .wr_data     (arr_data),
        .inv         (w_inv),
        .inv_idx     (w_idx)
    );

    assign hit    = rd_valid && (rd_tag == r_tag);
    assign w_hit  = probe_valid && (probe_tag == w_tag);
    assign w_acc  = WREN && !mem.MEM_LOADING;
    assign w_full = is_full_word(WSTRB, WADDR[1:0]);

    // A write accepted to the line being filled beats the fill: the fetched
    // word may predate the write, so the fill is dropped and the held read
    // replays through IDLE.
    assign fill_evt = (state == ST_FILL) && mem.MEM_RVALID;
    assign do_fill  = fill_evt && !(w_acc && (w_idx == r_idx));

    // The array has a single write port. If a fill to another line lands in
    // the same cycle as a full-word write hit, the write line is invalidated
    // instead of refreshed; memory already holds the new word.
    assign w_upd = w_acc && w_hit && w_full && !do_fill;
    assign w_inv = w_acc && w_hit && !(w_full && !do_fill);

    assign arr_we   = do_fill || w_upd;
    assign arr_idx  = do_fill ? r_idx : w_idx;
    assign arr_tag  = do_fill ? r_tag : w_tag;
    assign arr_data = do_fill ? mem.MEM_RDATA : WDATA;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RDEN && !hit) begin
                    state_nxt = ST_MISS;
                end
            end
            ST_MISS: begin
                rd_req = 1'b1;
                if (!mem.MEM_LOADING) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem.MEM_RVALID) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign LOADING = (RDEN && ((state != ST_IDLE) || !hit)) || mem.MEM_LOADING;

    assign mem.MEM_RSELECT = rd_req;
    assign mem.MEM_RDEN    = rd_req;
    assign mem.MEM_RIADDR  = {RADDR[31:2], 2'b00};
    assign mem.MEM_WSELECT = WREN;
    assign mem.MEM_WREN    = WREN;
    assign mem.MEM_WSTRB   = WSTRB;
    assign mem.MEM_WADDR   = WADDR;
    assign mem.MEM_WDATA   = WDATA;

    // The response address is not needed: only one fill is ever outstanding.
    assign unused_roaddr = ^mem.MEM_ROADDR;

    assign new_resp = (state == ST_IDLE) && RDEN && hit && !mem.MEM_LOADING;

    always_ff @(posedge CLK) begin
        if (RST) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            ROADDR <= '0;
        end else if (new_resp) begin
            RVALID <= 1'b1;
            RDATA  <= rd_data;
            ROADDR <= RADDR;
        end else if (!STALL) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
        end
    end

endmodule

// File: doc/dcache_dm_wt.md
DCACHE_DM_WT -- requirements
Module: dcache_dm_wt

Interface
REQ-001 Parameter INDEX_W, default 6, log2 of the line count (64 one-word lines).
REQ-002 Clock CLK, input, 1 bit, clock; all state updates on its rising edge.
REQ-003 Reset RST, input, 1 bit, synchronous, active-high.
REQ-004 STALL  in  1  pipeline stall; holds the response registers.
REQ-005 LOADING  out  1  core must hold its request while high.
REQ-006 RDEN  in  1  core read request.
REQ-007 RADDR  in  32  core read byte address.
REQ-008 RVALID / RDATA / ROADDR  out  1/32/32  registered read response.
REQ-009 WREN / WSTRB / WADDR / WDATA  in  1/4/32/32  core write request.
REQ-010 MEM_RSELECT, MEM_RDEN  out  1/1  read request to the AXI translate stage.
REQ-011 MEM_RIADDR  out  32  read address to the translate stage.
REQ-012 MEM_RVALID / MEM_RDATA / MEM_ROADDR  in  1/32/32  translate-stage read response.
REQ-013 MEM_WSELECT / MEM_WREN / MEM_WSTRB / MEM_WADDR / MEM_WDATA  out  1/1/4/32/32  write request to the translate stage.
REQ-014 MEM_LOADING  in  1  translate-stage busy.

Function
REQ-015 Address split: index = addr[INDEX_W+1:2]; tag = addr[31:INDEX_W+2]; addr[1:0] ignored for lookup.
REQ-016 Hit = valid[index] and stored tag equals the RADDR tag, evaluated combinationally.
REQ-017 States: IDLE, MISS, FILL.
REQ-018 IDLE: RDEN with miss -> MISS; LOADING=1 in the same cycle.
REQ-019 MISS: MEM_RSELECT=MEM_RDEN=1, MEM_RIADDR={RADDR[31:2],2'b00}; when MEM_LOADING==0 -> FILL.
REQ-020 FILL: MEM_RDEN=0; when MEM_RVALID, write MEM_RDATA/tag into the line, set valid, -> IDLE; otherwise stay in FILL.
REQ-021 LOADING = (RDEN && (state!=IDLE || !hit)) || MEM_LOADING.
REQ-022 Read hit in IDLE with LOADING low: on the next edge RVALID=1, RDATA=line data, ROADDR=RADDR; hit latency is 1 cycle.
REQ-023 A miss costs the translate-stage latency plus 2 cycles; the request is then served as a hit (replay).
REQ-024 Response registers: no new response and STALL=1 -> hold; neither -> RVALID=0, RDATA=0, ROADDR unchanged.
REQ-025 Writes are write-through and no-write-allocate.
REQ-026 MEM_WSELECT=MEM_WREN=WREN, with WSTRB/WADDR/WDATA passed through combinationally.
REQ-027 Write hit with WSTRB=4'b1111 and WADDR[1:0]=0: line data updated on the edge where MEM_LOADING==0 (write accepted).
REQ-028 Any other write hit: line invalidated at that edge.
REQ-029 Write miss: no cache change.
REQ-030 Simultaneous read and write to the same index: the write update/invalidate takes priority over the read fill; the read then replays.
REQ-031 Outputs to the memory side are combinational from state and inputs; there is no extra register stage.

Reset
REQ-032 RST: state=IDLE, all valid bits=0, RVALID=0, RDATA=0, ROADDR=0.
REQ-033 Data and tag arrays are not reset.
REQ-034 RST mid-MISS/FILL: discard the pending fill; the late MEM_RVALID is ignored in IDLE.

Structure
REQ-035 Shared package dcache_pkg holds the state encodings (IDLE=2'b00, MISS=2'b01, FILL=2'b11) and the INDEX_W default.
REQ-036 Sub-module dcache_dm_array: tag+data register array, one combinational read port, one write port, and a per-line valid vector with sync clear.

Verification
REQ-037 Cold read RADDR=0x100, translate stub returns 0xDEADBEEF after 3 cycles -> LOADING high through MISS/FILL, then RVALID=1, RDATA=0xDEADBEEF, ROADDR=0x100.
REQ-038 Repeat read 0x100 -> RVALID next cycle, no MEM_RDEN pulse.
REQ-039 Conflict read 0x200 (same index at INDEX_W=6) -> miss, refill; a following read of 0x100 misses again.
REQ-040 Full write 0x100 data 0x12345678 strobe 4'hF, then read 0x100 -> hit returning 0x12345678; MEM_WREN was asserted.
REQ-041 Byte write 0x101 strobe 4'h1, then read 0x100 -> miss, fetched from memory.
REQ-042 RST asserted in FILL, MEM_RVALID the next cycle -> valid bits stay 0, RVALID stays 0, state IDLE.
